// File: rtl/python_encoder.sv
// PYTHON-style link encoder: turns the fv/lv/pixel stream into 4-lane data words with
// a per-word sync code (FS/LS/IMG/LE/FE/BL/TR) and an optional per-line checksum word.
module python_encoder #(
    parameter int unsigned ROWS     = 64,
    parameter bit          CRC_EN   = 1'b1,
    parameter logic [7:0]  SYNC_FS  = 8'hAA,
    parameter logic [7:0]  SYNC_LS  = 8'h2A,
    parameter logic [7:0]  SYNC_FE  = 8'hCA,
    parameter logic [7:0]  SYNC_LE  = 8'h4A,
    parameter logic [7:0]  SYNC_IMG = 8'h35,
    parameter logic [7:0]  SYNC_BL  = 8'h15,
    parameter logic [7:0]  SYNC_TR  = 8'hE9,
    parameter logic [7:0]  SYNC_CRC = 8'h59,
    parameter logic [31:0] TR_DATA  = 32'hE9E9E9E9
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        fv,
    input  logic        lv,
    input  logic [31:0] d,
    output logic [31:0] data,
    output logic [7:0]  sync,
    output logic [2:0]  err
);
    localparam int unsigned      RowW    = $clog2(ROWS + 1);
    localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
    localparam logic [RowW-1:0] RowOne  = RowW'(1);
    localparam logic [1:0]      GapMin  = CRC_EN ? 2'd2 : 2'd1;

    localparam logic [1:0] StTrain = 2'd0;
    localparam logic [1:0] StBlank = 2'd1;
    localparam logic [1:0] StLine  = 2'd2;
    localparam logic [1:0] StCrc   = 2'd3;

    function automatic logic [31:0] lane_sum(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
        return s;
    endfunction

    logic            fv1_q, lv1_q, fvp_q, lvp_q;
    logic [31:0]     d1_q;
    logic [1:0]      state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [31:0]     acc_q, acc_d;
    logic [1:0]      gap_q, gap_d;
    logic [2:0]      err_q, err_d;
    logic [31:0]     data_q, data_d;
    logic [7:0]      sync_q, sync_d;

    logic fv_rise, lv_rise, last, cut, line_word, first;

    // Stage-1 word is classified using the raw input as its successor (lookahead).
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        acc_d     = acc_q;
        err_d     = err_q;
        data_d    = TR_DATA;
        sync_d    = SYNC_TR;
        line_word = 1'b0;
        first     = 1'b0;
        fv_rise   = fv1_q & ~fvp_q;
        lv_rise   = lv1_q & ~lvp_q;
        last      = ~(fv & lv);
        cut       = ~fv & lv;

        if (lv1_q) gap_d = 2'd0;
        else if (gap_q != 2'd2) gap_d = gap_q + 2'd1;
        else gap_d = gap_q;

        if (lv1_q && !fv1_q) err_d[1] = 1'b1;

        case (state_q)
            StTrain: begin
                if (fv_rise && lv_rise) begin
                    line_word = 1'b1;
                    first     = 1'b1;
                end else if (fv_rise) begin
                    state_d = StBlank;
                    data_d  = '0;
                    sync_d  = SYNC_BL;
                end
            end
            StBlank: begin
                if (!fv1_q) begin
                    state_d = StTrain;
                end else if (lv_rise && gap_q >= GapMin) begin
                    line_word = 1'b1;
                    first     = 1'b1;
                end else begin
                    // A line that starts too soon is blanked out until its lv falls.
                    if (lv_rise) err_d[0] = 1'b1;
                    data_d = '0;
                    sync_d = SYNC_BL;
                end
            end
            StLine: line_word = 1'b1;
            StCrc: begin
                data_d  = acc_q;
                sync_d  = SYNC_CRC;
                state_d = fv1_q ? StBlank : StTrain;
            end
            default: state_d = StTrain;
        endcase

        if (line_word) begin
            data_d  = d1_q;
            acc_d   = first ? d1_q : lane_sum(acc_q, d1_q);
            state_d = StLine;
            if (first) sync_d = (row_q == '0) ? SYNC_FS : SYNC_LS;
            else if (last) sync_d = (row_q == RowLast && !cut) ? SYNC_FE : SYNC_LE;
            else sync_d = SYNC_IMG;
            if (last) begin
                if (CRC_EN) state_d = StCrc;
                else state_d = fv ? StBlank : StTrain;
                row_d = (row_q == RowLast && !cut) ? '0 : row_q + RowOne;
            end
        end else if (!fv1_q && row_q != '0) begin
            // Frame ended before its last row.
            err_d[2] = 1'b1;
            row_d    = '0;
        end
    end

    always_ff @(posedge c) begin
        if (!rst_n) begin
            // Stage regs reset high so a level already high after reset is not a rise.
            fv1_q   <= 1'b1;
            lv1_q   <= 1'b1;
            fvp_q   <= 1'b1;
            lvp_q   <= 1'b1;
            d1_q    <= '0;
            state_q <= StTrain;
            row_q   <= '0;
            acc_q   <= '0;
            gap_q   <= 2'd2;
            err_q   <= '0;
            data_q  <= TR_DATA;
            sync_q  <= SYNC_TR;
        end else begin
            fv1_q   <= fv;
            lv1_q   <= lv;
            fvp_q   <= fv1_q;
            lvp_q   <= lv1_q;
            d1_q    <= d;
            state_q <= state_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            data_q  <= data_d;
            sync_q  <= sync_d;
        end
    end

    assign data = data_q;
    assign sync = sync_q;
    assign err  = err_q;

endmodule

// File: tb/tb_python_encoder.sv
// Directed bench for python_encoder (ROWS=2, CRC_EN=1); each cyc() drives one input word
// and checks the output word belonging to the previous input.
module tb_python_encoder;
    localparam logic [7:0]  SyncFs  = 8'hAA;
    localparam logic [7:0]  SyncLs  = 8'h2A;
    localparam logic [7:0]  SyncFe  = 8'hCA;
    localparam logic [7:0]  SyncLe  = 8'h4A;
    localparam logic [7:0]  SyncImg = 8'h35;
    localparam logic [7:0]  SyncBl  = 8'h15;
    localparam logic [7:0]  SyncTr  = 8'hE9;
    localparam logic [7:0]  SyncCrc = 8'h59;
    localparam logic [31:0] TrData  = 32'hE9E9E9E9;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic        fv = 1'b0;
    logic        lv = 1'b0;
    logic [31:0] d = '0;
    logic [31:0] data;
    logic [7:0]  sync;
    logic [2:0]  err;

    int n_vec = 0;
    int n_err = 0;

    python_encoder #(
        .ROWS   (2),
        .CRC_EN (1'b1)
    ) dut (
        .c     (c),
        .rst_n (rst_n),
        .fv    (fv),
        .lv    (lv),
        .d     (d),
        .data  (data),
        .sync  (sync),
        .err   (err)
    );

    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic l, input logic [31:0] dv,
                       input logic [7:0] es, input logic [31:0] ed, input string tag);
        @(negedge c);
        fv = f;
        lv = l;
        d  = dv;
        @(posedge c);
        #1;
        check({tag, ".sync"}, {24'h0, sync}, {24'h0, es});
        check({tag, ".data"}, data, ed);
    endtask

    initial begin
        // Reset with the link idle.
        rst_n = 1'b0;
        repeat (2) @(posedge c);
        #1;
        check("rst.sync", {24'h0, sync}, {24'h0, SyncTr});
        check("rst.data", data, TrData);
        check("rst.err", {29'h0, err}, 32'h0);
        @(negedge c);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0, SyncTr, TrData, "idle");
        check("idle.err", {29'h0, err}, 32'h0);

        // Frame A: two 4-word lines, 2-cycle gap.
        cyc(1'b1, 1'b0, 32'h0,        SyncTr,  TrData,       "a0");
        cyc(1'b1, 1'b1, 32'h01020304, SyncBl,  32'h0,        "a1");
        cyc(1'b1, 1'b1, 32'h01020304, SyncFs,  32'h01020304, "a2");
        cyc(1'b1, 1'b1, 32'h01020304, SyncImg, 32'h01020304, "a3");
        cyc(1'b1, 1'b1, 32'h01020304, SyncImg, 32'h01020304, "a4");
        cyc(1'b1, 1'b0, 32'h0,        SyncLe,  32'h01020304, "a5");
        cyc(1'b1, 1'b0, 32'h0,        SyncCrc, 32'h04080C10, "a6");
        cyc(1'b1, 1'b1, 32'h10203040, SyncBl,  32'h0,        "a7");
        cyc(1'b1, 1'b1, 32'h01010101, SyncLs,  32'h10203040, "a8");
        cyc(1'b1, 1'b1, 32'hFFFFFFFF, SyncImg, 32'h01010101, "a9");
        cyc(1'b1, 1'b1, 32'h80808080, SyncImg, 32'hFFFFFFFF, "a10");
        cyc(1'b0, 1'b0, 32'h0,        SyncFe,  32'h80808080, "a11");
        cyc(1'b0, 1'b0, 32'h0,        SyncCrc, 32'h90A0B0C0, "a12");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr,  TrData,       "a13");
        check("a.err", {29'h0, err}, 32'h0);

        // Frame B: fv/lv rise together, 1-cycle gap drops the next line.
        cyc(1'b1, 1'b1, 32'h11223344, SyncTr,  TrData,       "b0");
        cyc(1'b1, 1'b1, 32'h01FF0010, SyncFs,  32'h11223344, "b1");
        cyc(1'b1, 1'b0, 32'h0,        SyncLe,  32'h01FF0010, "b2");
        cyc(1'b1, 1'b1, 32'h55555555, SyncCrc, 32'h12213354, "b3");
        cyc(1'b1, 1'b1, 32'h55555555, SyncBl,  32'h0,        "b4");
        cyc(1'b1, 1'b0, 32'h0,        SyncBl,  32'h0,        "b5");
        cyc(1'b1, 1'b0, 32'h0,        SyncBl,  32'h0,        "b6");
        cyc(1'b1, 1'b1, 32'hDEADBEEF, SyncBl,  32'h0,        "b7");
        cyc(1'b1, 1'b1, 32'h01010101, SyncLs,  32'hDEADBEEF, "b8");
        cyc(1'b0, 1'b0, 32'h0,        SyncFe,  32'h01010101, "b9");
        cyc(1'b0, 1'b0, 32'h0,        SyncCrc, 32'hDFAEBFF0, "b10");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr,  TrData,       "b11");
        check("b.err", {29'h0, err}, 32'h1);

        // Frame C: one-word first line, then fv drops early.
        cyc(1'b1, 1'b0, 32'h0,        SyncTr,  TrData,       "c0");
        cyc(1'b1, 1'b1, 32'hA5A5A5A5, SyncBl,  32'h0,        "c1");
        cyc(1'b1, 1'b0, 32'h0,        SyncFs,  32'hA5A5A5A5, "c2");
        cyc(1'b1, 1'b0, 32'h0,        SyncCrc, 32'hA5A5A5A5, "c3");
        cyc(1'b0, 1'b0, 32'h0,        SyncBl,  32'h0,        "c4");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr,  TrData,       "c5");
        check("c.err", {29'h0, err}, 32'h5);

        // Frame D: restarts with FS, then reset mid-line.
        cyc(1'b1, 1'b1, 32'h12345678, SyncTr,  TrData,       "d0");
        cyc(1'b1, 1'b1, 32'h9ABCDEF0, SyncFs,  32'h12345678, "d1");
        cyc(1'b1, 1'b1, 32'h9ABCDEF0, SyncImg, 32'h9ABCDEF0, "d2");
        @(negedge c);
        rst_n = 1'b0;
        @(posedge c);
        #1;
        check("mrst.sync", {24'h0, sync}, {24'h0, SyncTr});
        check("mrst.data", data, TrData);
        check("mrst.err", {29'h0, err}, 32'h0);
        @(negedge c);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 32'h9ABCDEF0, SyncTr, TrData, "r0");
        cyc(1'b1, 1'b0, 32'h0,        SyncTr, TrData, "r1");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr, TrData, "r2");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr, TrData, "r3");
        check("r.err", {29'h0, err}, 32'h0);

        // Frame E: row back at 0 after reset, then lv high with fv low.
        cyc(1'b1, 1'b1, 32'hCAFEF00D, SyncTr,  TrData,       "e0");
        cyc(1'b1, 1'b0, 32'h0,        SyncFs,  32'hCAFEF00D, "e1");
        cyc(1'b0, 1'b0, 32'h0,        SyncCrc, 32'hCAFEF00D, "e2");
        cyc(1'b0, 1'b1, 32'h77777777, SyncTr,  TrData,       "e3");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr,  TrData,       "e4");
        cyc(1'b0, 1'b0, 32'h0,        SyncTr,  TrData,       "e5");
        check("e.err", {29'h0, err}, 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
